uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver for the `ser_rxd` pin of mips_top. It is the receive-side counterpart of the core's serial transmitter that drives `ser_txd`.
- Samples the line at 16x oversampling and majority-votes each bit.
- Presents a received byte to the bus-side peripheral logic with a ready/read handshake, plus frame-error and overrun status.

Parameters:
- BAUD_DIV, 27: clk cycles per oversample tick (50 MHz / 16 / 115200). Legal range 2..65535.
- OVS, 16: oversample ticks per bit. Fixed; do not change.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- ser_rxd  input  1  serial line; idles high; asynchronous to clk
- rd  input  1  one-cycle read strobe from the host; acknowledges the held byte
- rx_data  output  8  last received byte; stable while rx_ready=1
- rx_ready  output  1  byte available
- frame_err  output  1  stop bit of the held byte sampled low
- overrun  output  1  a byte was lost because rx_ready was still set
- rx_busy  output  1  frame reception in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; counters and shift register cleared.
  - Sync flops set to 1.
  - rx_data=0x00, rx_ready=0, frame_err=0, overrun=0, rx_busy=0.
  - Reset mid-frame abandons the frame; nothing is delivered.
- Input sync: two flops on ser_rxd, reset to 1. Call the synchronized value rxd_s.
- Tick generator:
  - Free-running counter 0..BAUD_DIV-1.
  - tick=1 for one clk when the counter equals BAUD_DIV-1.
  - The counter is not restarted by frame events.
- States and transitions:
  - IDLE: on a tick with rxd_s=0 -> START, with sample_cnt=0.
  - START, DATA, STOP: sample_cnt increments on each tick (0..15). Capture rxd_s at sample_cnt 7, 8 and 9. The bit value is the majority of the three samples.
  - START: at cnt 9, majority=1 -> IDLE (false start, no status change). At cnt 15 -> DATA with bit_idx=0.
  - DATA: at cnt 15, shift the majority into the shift register LSB-first and increment bit_idx. After bit_idx 7 -> STOP.
  - STOP: at cnt 9, complete the frame and go to IDLE. The state machine can therefore detect the next start bit from the second half of the stop bit onward.
- Frame completion (registered on the clk after the STOP cnt-9 tick):
  - If rx_ready=0, or rd=1 in the same cycle: rx_data<=shift, rx_ready<=1, frame_err<=~majority, overrun<=0.
  - If rx_ready=1 and rd=0: rx_data and frame_err are unchanged and overrun<=1 (the new byte is dropped).
  - A byte with a low stop bit is still delivered, with frame_err=1.
- Read:
  - rd=1 with rx_ready=1 clears rx_ready, frame_err and overrun on the next clk, unless a completion happens in the same cycle (see Frame completion).
  - rd=1 with rx_ready=0 is ignored.
- Latency: rx_ready rises about 9.6 bit times after the falling edge of the start bit. The exact value is 2 sync cycles + tick phase + (9*16+9) ticks + 1 clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and samples one even-parity bit like a data bit.
  - Output port parity_err (1 bit) is added. It is updated and cleared together with frame_err and is set when XOR(data, parity bit)=1.
- When undefined:
  - No PARITY state and no parity_err port; behaviour is pure 8N1.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - OVS=16, SAMPLE_LO=7, SAMPLE_MID=8, SAMPLE_HI=9, LAST_SAMPLE=15;
  - DATA_BITS=8.
- One sub-module, uart_baud_tick: the BAUD_DIV tick counter. uart_rx instantiates it; the future uart_tx will reuse it.

Test Plan (BAUD_DIV=4, so 1 bit = 64 clk; the bench drives ser_rxd):
- Send 0x55 8N1 -> rx_ready=1 and rx_data=0x55 within 620 clk of the start edge; frame_err=0, overrun=0; rd pulse -> rx_ready=0 on the next clk.
- Low glitch of 12 clk on an idle line -> rx_busy pulses and then returns to 0; rx_ready stays 0 and all status bits stay 0.
- Send 0xA3 with the stop bit forced low -> rx_data=0xA3, frame_err=1; rd clears frame_err.
- Send 0x11 then 0x22 back-to-back with no rd -> rx_data=0x11, overrun=1 after the second frame; rd clears all status. Repeat with rd issued in the same cycle as 0x22 completes -> rx_data=0x22, rx_ready=1, overrun=0.
- Assert rst=0 for 10 clk in the middle of data bit 4 of 0xFF -> all outputs 0 immediately; after release, a following 0x3C is received correctly with frame_err=0.
- With UART_RX_PARITY_EN: send 0x07 with parity 1 -> parity_err=0; send 0x07 with parity 0 -> parity_err=1 and rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encoding, oversampling
// constants and the 2-of-3 majority vote used for bit decisions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int         OVS         = 16;
    localparam logic [3:0] SAMPLE_LO   = 4'd7;
    localparam logic [3:0] SAMPLE_MID  = 4'd8;
    localparam logic [3:0] SAMPLE_HI   = 4'd9;
    localparam logic [3:0] LAST_SAMPLE = 4'd15;
    localparam int         DATA_BITS   = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle pulse every BAUD_DIV clocks.
// Shared by the UART receiver and transmitter; never restarted by frame events.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int              CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampling with 2-of-3 majority vote per bit.
// Optional even parity (PARITY state and parity_err port) with UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_rxd,
    input  logic       rd,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);
    localparam int CNT_W = $clog2(OVS);

    logic             tick;
    logic             sync1_reg;
    logic             rxd_s;
    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [1:0]       samp_reg, samp_next;
    logic             bit_reg, bit_next;
    logic             stop_reg, stop_next;
    logic             done_reg, done_next;
    logic             maj_now;
    logic [7:0]       rx_data_reg;
    logic             rx_ready_reg, frame_err_reg, overrun_reg;
`ifdef UART_RX_PARITY_EN
    logic             par_reg, par_next;
    logic             parity_err_reg;
`endif

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            rxd_s     <= 1'b1;
        end else begin
            sync1_reg <= ser_rxd;
            rxd_s     <= sync1_reg;
        end
    end

    // Vote uses the stored samples 7 and 8 plus the live sample 9.
    assign maj_now = majority3(samp_reg[0], samp_reg[1], rxd_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            samp_reg    <= '0;
            bit_reg     <= 1'b0;
            stop_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            samp_reg    <= samp_next;
            bit_reg     <= bit_next;
            stop_reg    <= stop_next;
            done_reg    <= done_next;
`ifdef UART_RX_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        samp_next    = samp_reg;
        bit_next     = bit_reg;
        stop_next    = stop_reg;
        done_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_next     = par_reg;
`endif
        if (tick) begin
            if (state_reg == IDLE) begin
                // The detecting tick is sample 0 of the start bit, so counting resumes at 1.
                if (!rxd_s) begin
                    state_next = START;
                    cnt_next   = CNT_W'(1);
                end
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == SAMPLE_LO)  samp_next[0] = rxd_s;
                if (cnt_reg == SAMPLE_MID) samp_next[1] = rxd_s;
                if (cnt_reg == SAMPLE_HI)  bit_next     = maj_now;
                case (state_reg)
                    START: begin
                        if (cnt_reg == SAMPLE_HI && maj_now) begin
                            state_next = IDLE;
                        end else if (cnt_reg == LAST_SAMPLE) begin
                            state_next   = DATA;
                            bit_idx_next = '0;
                        end
                    end
                    DATA: begin
                        if (cnt_reg == LAST_SAMPLE) begin
                            shift_next   = {bit_reg, shift_reg[7:1]};
                            bit_idx_next = bit_idx_reg + 3'd1;
                            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state_next = PARITY;
`else
                                state_next = STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt_reg == LAST_SAMPLE) begin
                            par_next   = bit_reg;
                            state_next = STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt_reg == SAMPLE_HI) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                            stop_next  = maj_now;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // A read in the completion cycle frees the holding register for the new byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data_reg    <= '0;
            rx_ready_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else if (done_reg && (!rx_ready_reg || rd)) begin
            rx_data_reg    <= shift_reg;
            rx_ready_reg   <= 1'b1;
            frame_err_reg  <= ~stop_reg;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= ^{shift_reg, par_reg};
`endif
        end else if (done_reg) begin
            overrun_reg    <= 1'b1;
        end else if (rd && rx_ready_reg) begin
            rx_ready_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end
    end

    assign rx_data   = rx_data_reg;
    assign rx_ready  = rx_ready_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
    assign rx_busy   = (state_reg != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (BAUD_DIV=4, 64 clk per bit); covers the
// parity option when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    localparam int BAUD_DIV = 4;
    localparam int BIT_CLK  = 16 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ser_rxd = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready, frame_err, overrun, rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int ready_rise_cyc = -1;
    logic ready_d = 1'b0;

    // Reference model of the host-visible holding register.
    logic [7:0] exp_data  = 8'h00;
    logic       exp_ready = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;
    logic       exp_perr  = 1'b0;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_rxd   (ser_rxd),
        .rd        (rd),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_ready && !ready_d) ready_rise_cyc = cyc;
        ready_d = rx_ready;
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_byte({tag, "_data"},  rx_data,   exp_data);
        check_bit ({tag, "_ready"}, rx_ready,  exp_ready);
        check_bit ({tag, "_ferr"},  frame_err, exp_ferr);
        check_bit ({tag, "_ovr"},   overrun,   exp_ovr);
        check_bit ({tag, "_busy"},  rx_busy,   1'b0);
`ifdef UART_RX_PARITY_EN
        check_bit ({tag, "_perr"},  parity_err, exp_perr);
`endif
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic pbit);
        if (!exp_ready) begin
            exp_data  = b;
            exp_ready = 1'b1;
            exp_ferr  = ~stop_bit;
            exp_ovr   = 1'b0;
            exp_perr  = ^{b, pbit};
        end else begin
            exp_ovr   = 1'b1;
        end
    endtask

    task automatic model_reset();
        exp_data = 8'h00; exp_ready = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    endtask

    task automatic do_read();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
        if (exp_ready) begin
            exp_ready = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
        end
        $display("read  rx_data=0x%02h", rx_data);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pbit);
        @(negedge clk);
        start_cyc = cyc;
        ser_rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rxd = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        ser_rxd = pbit;
        repeat (BIT_CLK) @(negedge clk);
`endif
        ser_rxd = stop_bit;
        repeat (BIT_CLK) @(negedge clk);
        ser_rxd = 1'b1;
        $display("frame data=0x%02h stop=%0b parity=%0b", b, stop_bit, pbit);
    endtask

    initial begin
        logic [7:0] b;
        logic       sb, pb, saw_busy, got_rise, got_fall;
        int         lat;

        // Reset state
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);

        // 0x55, latency bound, read clears rx_ready
        ready_rise_cyc = -1;
        send_frame(8'h55, 1'b1, 1'b0);
        model_frame(8'h55, 1'b1, 1'b0);
        check_all("t55");
        lat = ready_rise_cyc - start_cyc;
        check_bit("t55_latency", (ready_rise_cyc >= 0) && (lat > 0) && (lat <= 620), 1'b1);
        do_read();
        check_bit("t55_rd_clear", rx_ready, 1'b0);

        // 12-clk low glitch on idle line
        repeat (BIT_CLK) @(negedge clk);
        saw_busy = 1'b0;
        ser_rxd = 1'b0;
        repeat (12) begin @(negedge clk); saw_busy |= rx_busy; end
        ser_rxd = 1'b1;
        repeat (150) begin @(negedge clk); saw_busy |= rx_busy; end
        $display("glitch 12 clk");
        check_bit("glitch_busy_seen", saw_busy, 1'b1);
        check_all("glitch");

        // Low stop bit
        send_frame(8'hA3, 1'b0, 1'b0);
        model_frame(8'hA3, 1'b0, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        check_all("ta3");
        do_read();
        check_all("ta3_rd");

        // Overrun: 0x11 then 0x22 with no read
        send_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h11, 1'b1, 1'b0);
        check_all("t11");
        send_frame(8'h22, 1'b1, 1'b0);
        model_frame(8'h22, 1'b1, 1'b0);
        check_all("t22_ovr");
        do_read();
        check_all("t22_rd");

        // Read issued in the completion cycle of 0x22
        send_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h11, 1'b1, 1'b0);
        check_all("t11b");
        got_rise = 1'b0;
        got_fall = 1'b0;
        fork
            send_frame(8'h22, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 100 && !got_rise; i++) begin
                    @(negedge clk);
                    if (rx_busy) got_rise = 1'b1;
                end
                for (int i = 0; i < 800 && got_rise && !got_fall; i++) begin
                    @(negedge clk);
                    if (!rx_busy) got_fall = 1'b1;
                end
                if (got_fall) begin
                    rd = 1'b1;
                    @(negedge clk) rd = 1'b0;
                end
            end
        join
        check_bit("t22b_busy_timing", got_fall, 1'b1);
        exp_ready = 1'b0;
        model_frame(8'h22, 1'b1, 1'b0);
        check_all("t22b_same_cycle_rd");

        // Reset in the middle of data bit 4 of 0xFF
        @(negedge clk);
        ser_rxd = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        ser_rxd = 1'b1;
        repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        $display("reset pulse in data bit 4");
        repeat (2 * BIT_CLK) @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b0);
        check_all("t3c");
        do_read();

        // Randomized frames against the model
        for (int k = 0; k < 8; k++) begin
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            pb = (^b) ^ ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 40)) @(negedge clk);
            send_frame(b, sb, pb);
            model_frame(b, sb, pb);
            if (!sb) repeat (BIT_CLK) @(negedge clk);
            check_all($sformatf("rnd%0d", k));
            if ($urandom_range(0, 1) == 1) begin
                do_read();
                check_all($sformatf("rnd%0d_rd", k));
            end
        end
        do_read();

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        model_frame(8'h07, 1'b1, 1'b1);
        check_all("par_ok");
        do_read();
        send_frame(8'h07, 1'b1, 1'b0);
        model_frame(8'h07, 1'b1, 1'b0);
        check_all("par_bad");
        check_bit("par_bad_flag", parity_err, 1'b1);
        do_read();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
